// File: rtl/ami_wr_req_arb_pkg.sv
// ---------------------------------------------------------------------------
// ami_wr_req_arb_pkg
// Shared types and constants for the AMI write-request arbiter slice.
//   AMIRequest             : request word carried on every AMI request port
//   F1_AMI_WrArb_NumPorts  : port count used by parents that instantiate the
//                            arbiter (feeds NUM_PORTS)
//   rr_next()              : round-robin successor with an explicit wrap, so
//                            non-power-of-two port counts wrap correctly
// ---------------------------------------------------------------------------
package ami_wr_req_arb_pkg;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  size;
  } AMIRequest;

  localparam int F1_AMI_WrArb_NumPorts = 4;

  function automatic int rr_next(input int sel, input int n);
    return (sel == n - 1) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/ami_wr_req_arb_if.sv
// ---------------------------------------------------------------------------
// ami_wr_req_arb_if
// Bundle of the arbiter's request/grant signals.
//   in_req[NUM_PORTS]  : per-port AMI requests (upstream -> arbiter)
//   in_grant           : per-port accept pulse, one-hot or zero (arbiter -> upstream)
//   out_req / out_port : registered request and its source port (arbiter -> write path)
//   out_grant          : write path accepted out_req (write path -> arbiter)
//   arb_busy           : slot occupied or any candidate pending
// Modports: master = the arbiter, slave = its environment.
// ---------------------------------------------------------------------------
interface ami_wr_req_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) ();
  import ami_wr_req_arb_pkg::*;

  AMIRequest              in_req [NUM_PORTS];
  logic [NUM_PORTS-1:0]   in_grant;
  AMIRequest              out_req;
  logic [PORT_W-1:0]      out_port;
  logic                   out_grant;
  logic                   arb_busy;

  modport master (
    input  in_req, out_grant,
    output in_grant, out_req, out_port, arb_busy
  );

  modport slave (
    output in_req, out_grant,
    input  in_grant, out_req, out_port, arb_busy
  );
endinterface

// File: rtl/ami_wr_req_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Cyclic priority encoder: finds the first set bit of req searching upward
// from ptr and wrapping at N. Purely combinational; shared by the read and
// write arbiters.
//   req[N-1:0] : request vector
//   ptr        : starting index (must be < N)
//   any        : at least one request bit set
//   sel        : index of the winning request (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] sel
);

  // Walk offsets from the farthest to the nearest so the nearest hit is the
  // last assignment and therefore wins.
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        any = 1'b1;
        sel = W'(idx);
      end
    end
  end

endmodule

// File: rtl/ami_wr_req_arb.sv
// ---------------------------------------------------------------------------
// ami_wr_req_arb
// Round-robin merge of NUM_PORTS AMI write-request ports into one registered
// AMIRequest stream for a DDR channel's write path. One cycle of latency,
// one accept per cycle; the output slot is frozen until out_grant.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : ami_wr_req_arb_if.master (in_req/in_grant/out_req/out_port/
//               out_grant/arb_busy)
// Optional build macro AMI_WR_ARB_STATS_EN adds:
//   stat_accept_cnt[NUM_PORTS] : saturating per-port accept counters
//   stat_stall_cnt             : saturating count of cycles the slot waited
// ---------------------------------------------------------------------------
module ami_wr_req_arb
  import ami_wr_req_arb_pkg::*;
#(
  parameter int NUM_PORTS = F1_AMI_WrArb_NumPorts,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  ami_wr_req_arb_if.master      bus
`ifdef AMI_WR_ARB_STATS_EN
  ,
  output logic [31:0]           stat_accept_cnt [NUM_PORTS],
  output logic [31:0]           stat_stall_cnt
`endif
);

  logic                 slot_v_q,    slot_v_d;
  AMIRequest            slot_req_q,  slot_req_d;
  logic [PORT_W-1:0]    slot_port_q, slot_port_d;
  logic [PORT_W-1:0]    rr_ptr_q,    rr_ptr_d;

  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] grant;
  logic                 any;
  logic [PORT_W-1:0]    sel;
  logic                 slot_free;
  logic                 load;

  // Reads (isWrite=0) are simply not candidates, so they never block others.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
    assign cand[gi]  = bus.in_req[gi].valid && bus.in_req[gi].isWrite;
    assign grant[gi] = load && (sel == PORT_W'(gi));
  end

  rr_pick #(.N(NUM_PORTS), .W(PORT_W)) u_pick (
    .req (cand),
    .ptr (rr_ptr_q),
    .any (any),
    .sel (sel)
  );

  // No grant during reset: the slot is being cleared, so an accept would be lost.
  assign slot_free = !slot_v_q || bus.out_grant;
  assign load      = slot_free && any && !rst;

  always_comb begin
    slot_v_d    = slot_v_q;
    slot_req_d  = slot_req_q;
    slot_port_d = slot_port_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) slot_v_d = any;
    if (load) begin
      slot_req_d  = bus.in_req[sel];
      slot_port_d = sel;
      rr_ptr_d    = PORT_W'(rr_next(int'(sel), NUM_PORTS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q    <= 1'b0;
      slot_req_q  <= '0;
      slot_port_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_req_q  <= slot_req_d;
      slot_port_q <= slot_port_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Stale payload stays in the slot after a drain; valid comes from slot_v only.
  always_comb begin
    bus.out_req       = slot_req_q;
    bus.out_req.valid = slot_v_q;
  end

  assign bus.in_grant = grant;
  assign bus.out_port = slot_port_q;
  assign bus.arb_busy = slot_v_q || (|cand);

`ifdef AMI_WR_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_acc
    logic [31:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (grant[gi] && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign stat_accept_cnt[gi] = cnt_q;
  end

  logic [31:0] stall_q, stall_d;
  always_comb begin
    stall_d = stall_q;
    if (slot_v_q && !bus.out_grant && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
  assign stat_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ami_wr_req_arb.sv
// ---------------------------------------------------------------------------
// tb_ami_wr_req_arb
// Self-checking bench for ami_wr_req_arb (NUM_PORTS=4). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Stats checks are compiled in when AMI_WR_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_ami_wr_req_arb;
  import ami_wr_req_arb_pkg::*;

  localparam int NP = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   og_empty;

  ami_wr_req_arb_if #(.NUM_PORTS(NP)) bus ();

`ifdef AMI_WR_ARB_STATS_EN
  logic [31:0] stat_accept_cnt [NP];
  logic [31:0] stat_stall_cnt;
`endif

  ami_wr_req_arb #(.NUM_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef AMI_WR_ARB_STATS_EN
    ,
    .stat_accept_cnt (stat_accept_cnt),
    .stat_stall_cnt  (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out_grant with an empty slot is legal-but-meaningless; the design ignores it.
  always @(negedge clk)
    if (!rst && bus.out_grant && !bus.out_req.valid) og_empty++;

  function automatic AMIRequest mk_req(input bit wr, input logic [63:0] addr,
                                       input logic [63:0] data);
    AMIRequest r;
    r = '0;
    r.valid = 1'b1;
    r.isWrite = wr;
    r.addr = addr;
    r.data = data;
    r.size = 8'd64;
    return r;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < NP; i++) bus.in_req[i] = '0;
    bus.out_grant = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (bus.out_req.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_req.valid); end
    n_checks++; if (bus.out_req.addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.out_req.addr); end
    n_checks++; if (bus.out_port !== 2'd0) begin n_fail++; $display("FAIL reset_port: got %0d want 0", bus.out_port); end
    n_checks++; if (bus.in_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.in_grant); end
    n_checks++; if (bus.arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.arb_busy); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.in_req[2] = mk_req(1'b1, 64'h40, 64'h1234);
    bus.out_grant = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", bus.in_grant); end
    tick();
    bus.in_req[2] = '0;
    bus.in_req[0] = mk_req(1'b1, 64'h100, 64'h0);
    bus.in_req[3] = mk_req(1'b1, 64'h300, 64'h3);
    @(negedge clk);
    n_checks++; if (bus.out_req.valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.out_req.valid); end
    n_checks++; if (bus.out_req.addr !== 64'h40) begin n_fail++; $display("FAIL single_addr: got %h want 40", bus.out_req.addr); end
    n_checks++; if (bus.out_port !== 2'd2) begin n_fail++; $display("FAIL single_port: got %0d want 2", bus.out_port); end
    // rr_ptr is now 3, so port 3 beats port 0
    n_checks++; if (bus.in_grant !== 4'b1000) begin n_fail++; $display("FAIL single_ptr3: got %b want 1000", bus.in_grant); end
    tick();
    clear_inputs();
    bus.out_grant = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.out_port !== 2'd3 || bus.out_req.addr !== 64'h300) begin n_fail++; $display("FAIL single_next: port %0d addr %h want 3/300", bus.out_port, bus.out_req.addr); end
    tick();
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int i = 0; i < NP; i++) bus.in_req[i] = mk_req(1'b1, 64'(i * 16), 64'(i));
    bus.out_grant = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic [3:0] e;
      e = 4'(1 << (c % NP));
      @(negedge clk);
      n_checks++; if (bus.in_grant !== e) begin n_fail++; $display("FAIL rr_order cyc %0d: got %b want %b", c, bus.in_grant, e); end
      if (c > 0) begin
        n_checks++; if (bus.out_port !== 2'((c - 1) % NP)) begin n_fail++; $display("FAIL rr_port cyc %0d: got %0d want %0d", c, bus.out_port, (c - 1) % NP); end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    bus.in_req[1] = mk_req(1'b1, 64'hA1, 64'hD1);
    @(negedge clk);
    n_checks++; if (bus.in_grant !== 4'b0010) begin n_fail++; $display("FAIL stall_load: got %b want 0010", bus.in_grant); end
    tick();
    bus.in_req[1] = '0;
    bus.in_req[0] = mk_req(1'b1, 64'hA0, 64'hD0);
    bus.in_req[3] = mk_req(1'b1, 64'hA3, 64'hD3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (bus.in_grant !== 4'b0000) begin n_fail++; $display("FAIL stall_grant cyc %0d: got %b want 0000", c, bus.in_grant); end
      n_checks++; if (bus.out_req.valid !== 1'b1 || bus.out_req.addr !== 64'hA1 || bus.out_req.data !== 64'hD1 || bus.out_port !== 2'd1)
        begin n_fail++; $display("FAIL stall_hold cyc %0d: v %b addr %h data %h port %0d want 1/a1/d1/1", c, bus.out_req.valid, bus.out_req.addr, bus.out_req.data, bus.out_port); end
      tick();
    end
    bus.out_grant = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_grant !== 4'b1000) begin n_fail++; $display("FAIL stall_release: got %b want 1000", bus.in_grant); end
    tick();
    clear_inputs();
    bus.out_grant = 1'b1;
    tick();
  endtask

  task automatic test_read_ignored();
    do_reset();
    bus.in_req[0] = mk_req(1'b0, 64'hF0, 64'h0);
    bus.in_req[1] = mk_req(1'b1, 64'hF1, 64'h1);
    bus.out_grant = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++; if (bus.in_grant !== 4'b0010) begin n_fail++; $display("FAIL read_ign cyc %0d: got %b want 0010", c, bus.in_grant); end
      tick();
    end
    bus.in_req[1] = '0;
    @(negedge clk);
    n_checks++; if (bus.in_grant !== 4'b0000) begin n_fail++; $display("FAIL read_only_grant: got %b want 0000", bus.in_grant); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.arb_busy !== 1'b0 || bus.out_req.valid !== 1'b0) begin n_fail++; $display("FAIL read_only_busy: busy %b valid %b want 0/0", bus.arb_busy, bus.out_req.valid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in_req[2] = mk_req(1'b1, 64'hB2, 64'h2);
    tick();
    bus.in_req[2] = '0;
    bus.in_req[0] = mk_req(1'b1, 64'hB0, 64'h0);
    bus.in_req[3] = mk_req(1'b1, 64'hB3, 64'h3);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant_in_rst: got %b want 0000", bus.in_grant); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_req.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus.out_req.valid); end
    n_checks++; if (bus.in_grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first: got %b want 0001", bus.in_grant); end
    tick();
    clear_inputs();
    bus.out_grant = 1'b1;
    tick();
  endtask

  task automatic test_random();
    AMIRequest  pend_req [NP];
    bit         pend [NP];
    bit         m_v;
    AMIRequest  m_req;
    int         m_port;
    int         m_ptr;
    do_reset();
    m_v = 1'b0; m_req = '0; m_port = 0; m_ptr = 0;
    for (int i = 0; i < NP; i++) begin pend[i] = 1'b0; pend_req[i] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit free, any;
      int sel;
      logic [NP-1:0] exp_grant;
      for (int i = 0; i < NP; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pend_req[i] = mk_req($urandom_range(0, 4) != 0, {$urandom, $urandom}, {$urandom, $urandom});
        end else if (pend[i] && !pend_req[i].isWrite && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b0;
        end
        bus.in_req[i] = pend[i] ? pend_req[i] : '0;
      end
      bus.out_grant = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      free = !m_v || bus.out_grant;
      any = 1'b0; sel = 0;
      for (int k = 0; k < NP; k++) begin
        int idx;
        idx = (m_ptr + k) % NP;
        if (!any && pend[idx] && pend_req[idx].isWrite) begin any = 1'b1; sel = idx; end
      end
      exp_grant = '0;
      if (free && any) exp_grant[sel] = 1'b1;
      n_checks++; if (bus.in_grant !== exp_grant) begin n_fail++; $display("FAIL rand_grant cyc %0d: got %b want %b", cyc, bus.in_grant, exp_grant); end
      n_checks++; if (bus.out_req.valid !== m_v) begin n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, bus.out_req.valid, m_v); end
      n_checks++; if (bus.arb_busy !== (m_v || any)) begin n_fail++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, bus.arb_busy, m_v || any); end
      if (m_v) begin
        n_checks++; if (bus.out_req.addr !== m_req.addr || bus.out_req.data !== m_req.data || bus.out_port !== 2'(m_port))
          begin n_fail++; $display("FAIL rand_slot cyc %0d: addr %h data %h port %0d want %h %h %0d", cyc, bus.out_req.addr, bus.out_req.data, bus.out_port, m_req.addr, m_req.data, m_port); end
      end
      if (free) begin
        if (any) begin
          m_v = 1'b1; m_req = pend_req[sel]; m_port = sel; m_ptr = (sel + 1) % NP;
          pend[sel] = 1'b0;
        end else begin
          m_v = 1'b0;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef AMI_WR_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.in_req[1] = mk_req(1'b1, 64'hC1, 64'h1);
    bus.out_grant = 1'b1;
    repeat (10) begin @(negedge clk); tick(); end
    clear_inputs();
    repeat (3) begin @(negedge clk); tick(); end
    @(negedge clk);
    n_checks++; if (stat_accept_cnt[1] !== 32'd10) begin n_fail++; $display("FAIL stats_accept1: got %0d want 10", stat_accept_cnt[1]); end
    n_checks++; if (stat_accept_cnt[0] !== 32'd0) begin n_fail++; $display("FAIL stats_accept0: got %0d want 0", stat_accept_cnt[0]); end
    n_checks++; if (stat_stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stats_stall: got %0d want 3", stat_stall_cnt); end
    tick();
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0; og_empty = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_rr_order();
    test_stall();
    test_read_ignored();
    test_reset_mid();
    test_random();
`ifdef AMI_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("note: %0d cycles saw out_grant with an empty slot", og_empty);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
